// File: rtl/fsquare_iter_if.sv
// Request/result bundle for the iterative single-precision squaring unit.
interface fsquare_iter_if;
    logic [31:0] d;
    logic [1:0]  rm;
    logic        fsq;
    logic        ena;
    logic [31:0] s;
    logic        busy;
    logic        stall;
    logic [3:0]  count;

    modport master (output d, rm, fsq, ena, input  s, busy, stall, count);
    modport slave  (input  d, rm, fsq, ena, output s, busy, stall, count);
endinterface

// File: rtl/fsquare_iter.sv
// Multi-cycle IEEE-754 single squaring unit: radix-4 shift-add mantissa loop, then one round/pack cycle.
// Define FSQUARE_DENORM_EN to produce gradual-underflow (denormal) results instead of flushing to +0.
module fsquare_iter (
    input  logic          clk,
    input  logic          clrn,
    fsquare_iter_if.slave bus
);
    localparam int unsigned ITER = 12;
    localparam int unsigned MW   = 24;
    localparam int unsigned AW   = 48;

    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

    state_t        state;
    logic [MW-1:0] m_r;
    logic [7:0]    e_r;
    logic [1:0]    rm_r;
    logic          spec_r;
    logic [31:0]   spec_val_r;
    logic [AW-1:0] acc;
    logic [3:0]    count_r;
    logic [31:0]   s_r;
    logic          busy_r;

    assign bus.s     = s_r;
    assign bus.busy  = busy_r;
    assign bus.count = count_r;
    assign bus.stall = bus.fsq & (state != DONE);

    function automatic logic rnd_inc(input logic [1:0] mode, input logic lsb, input logic g, input logic st);
        case (mode)
            2'b00:   return g & (st | lsb);
            2'b10:   return g | st;
            default: return 1'b0;
        endcase
    endfunction

    // Special operand decode at acceptance; the result is carried through the full latency.
    logic        dec_spec;
    logic [31:0] dec_val;
    always_comb begin
        dec_spec = 1'b1;
        dec_val  = 32'h0;
        if (bus.d[30:23] == 8'hff) begin
            dec_val = (bus.d[22:0] != 23'h0) ? 32'h7fc0_0000 : 32'h7f80_0000;
        end else if (bus.d[30:23] == 8'h00) begin
`ifdef FSQUARE_DENORM_EN
            if (bus.d[22:0] != 23'h0 && bus.rm == 2'b10) dec_val = 32'h0000_0001;
`endif
        end else begin
            dec_spec = 1'b0;
        end
    end

    // One radix-4 digit of the multiplier per cycle, weighted by 4^count.
    logic [4:0]    sh;
    logic [1:0]    digit;
    logic [25:0]   pp;
    logic [AW-1:0] pp_sh;
    always_comb begin
        sh    = 5'(count_r) << 1;
        digit = 2'(m_r >> sh);
        pp    = (digit[0] ? 26'(m_r) : 26'h0) + (digit[1] ? {1'b0, m_r, 1'b0} : 26'h0);
        pp_sh = AW'(pp) << sh;
    end

    logic               p;
    logic [AW-1:0]      norm;
    logic signed [10:0] exp_pre;
    logic signed [10:0] exp_rnd;
    logic [23:0]        mant_rnd;
    logic [31:0]        rnd_val;
`ifdef FSQUARE_DENORM_EN
    logic [4:0]         dn_sh;
    logic [71:0]        ext;
    logic [23:0]        dn_rnd;
`endif
    always_comb begin
        p        = acc[47];
        norm     = p ? acc : (acc << 1);
        exp_pre  = $signed({2'b00, e_r, 1'b0}) - 11'sd127 + $signed({10'd0, p});
        mant_rnd = {1'b0, norm[46:24]} + 24'(rnd_inc(rm_r, norm[24], norm[23], |norm[22:0]));
        exp_rnd  = exp_pre + $signed({10'd0, mant_rnd[23]});
`ifdef FSQUARE_DENORM_EN
        dn_sh    = 5'(11'sd1 - exp_pre);
        ext      = {norm, 24'h0} >> dn_sh;
        dn_rnd   = ext[71:48] + 24'(rnd_inc(rm_r, ext[48], ext[47], |ext[46:0]));
`endif
        if (exp_pre <= 11'sd0) begin
`ifdef FSQUARE_DENORM_EN
            if (exp_pre >= -11'sd22) rnd_val = {8'h00, dn_rnd};
            else                     rnd_val = (rm_r == 2'b10) ? 32'h0000_0001 : 32'h0;
`else
            rnd_val = 32'h0;
`endif
        end else if (exp_rnd >= 11'sd255) begin
            rnd_val = (rm_r == 2'b00 || rm_r == 2'b10) ? 32'h7f80_0000 : 32'h7f7f_ffff;
        end else begin
            rnd_val = {1'b0, exp_rnd[7:0], mant_rnd[22:0]};
        end
    end

    // Control FSM and datapath registers, all gated by the pipeline enable.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            count_r    <= 4'd0;
            acc        <= '0;
            s_r        <= 32'h0;
            busy_r     <= 1'b0;
            m_r        <= '0;
            e_r        <= 8'h0;
            rm_r       <= 2'b00;
            spec_r     <= 1'b0;
            spec_val_r <= 32'h0;
        end else if (bus.ena) begin
            case (state)
                IDLE: if (bus.fsq) begin
                    m_r        <= {1'b1, bus.d[22:0]};
                    e_r        <= bus.d[30:23];
                    rm_r       <= bus.rm;
                    spec_r     <= dec_spec;
                    spec_val_r <= dec_val;
                    acc        <= '0;
                    count_r    <= 4'd0;
                    busy_r     <= 1'b1;
                    state      <= MUL;
                end
                MUL: begin
                    acc <= acc + pp_sh;
                    if (count_r == 4'(ITER - 1)) begin
                        count_r <= 4'd0;
                        state   <= ROUND;
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end
                ROUND: begin
                    s_r    <= spec_r ? spec_val_r : rnd_val;
                    busy_r <= 1'b0;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsquare_iter.sv
// Scoreboard bench for fsquare_iter: driver queues expected results, monitor checks them in DONE.
module tb_fsquare_iter;
    logic clk = 1'b0;
    logic clrn;

    fsquare_iter_if bus ();
    fsquare_iter dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic [1:0]  rm;
        logic [31:0] s;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, req);
        end
    endtask

    task automatic add(input string nm, input logic [31:0] d, input logic [1:0] rm, input logic [31:0] s);
        vec_t v;
        v.nm = nm; v.d = d; v.rm = rm; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic issue(input string nm, input logic [31:0] d, input logic [1:0] rm, input logic [31:0] s);
        bus.d   = d;
        bus.rm  = rm;
        bus.fsq = 1'b1;
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    // Counts falling edges from issue until stall drops; optionally freezes ena for 5 cycles.
    task automatic wait_done(input string nm, input int exp_lat, input int freeze_at);
        int   n    = 0;
        bit   done = 1'b0;
        bit   frz  = 1'b0;
        logic [3:0] held;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (!bus.stall) begin
                done = 1'b1;
            end else begin
                if (freeze_at < 0 && n == 1) chk({nm, "_busy_idle"}, 32'(bus.busy), 32'd0);
                if (freeze_at < 0 && n >= 2 && n <= 13) chk({nm, "_count"}, 32'(bus.count), 32'(n - 2));
                if (freeze_at >= 0 && !frz && bus.busy && bus.count == 4'(freeze_at)) begin
                    held    = bus.count;
                    bus.ena = 1'b0;
                    frz     = 1'b1;
                    repeat (5) begin
                        @(negedge clk);
                        n++;
                        chk({nm, "_frozen_count"}, 32'(bus.count), 32'(held));
                    end
                    bus.ena = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_in_%0d", nm, exp_lat);
        end else begin
            chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a held request with stall low marks the DONE cycle.
    string mon_nm;
    always @(negedge clk) begin
        if (clrn && bus.fsq && !bus.stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%08h required=none", bus.s);
            end else begin
                mon_nm = name_q.pop_front();
                chk(mon_nm, bus.s, exp_q.pop_front());
                chk({mon_nm, "_busy_done"}, 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        int  n;
        bit  hit;

        bus.d = 32'h0; bus.rm = 2'b00; bus.fsq = 1'b0; bus.ena = 1'b1;
        clrn = 1'b0;
        #2;
        chk("rst_s", bus.s, 32'h0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall_low", 32'(bus.stall), 32'd0);
        bus.fsq = 1'b1;
        #1;
        chk("rst_stall_fsq", 32'(bus.stall), 32'd1);
        bus.fsq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;

        add("sq3",      32'h4040_0000, 2'd0, 32'h4110_0000);
        add("neg2",     32'hc000_0000, 2'd0, 32'h4080_0000);
        add("sq1p5",    32'h3fc0_0000, 2'd0, 32'h4010_0000);
        add("ulp_rne",  32'h3f80_0001, 2'd0, 32'h3f80_0002);
        add("ulp_up",   32'h3f80_0001, 2'd2, 32'h3f80_0003);
        add("ulp_rz",   32'h3f80_0001, 2'd3, 32'h3f80_0002);
        add("tie_rne",  32'h3f80_0800, 2'd0, 32'h3f80_1000);
        add("tie_up",   32'h3f80_0800, 2'd2, 32'h3f80_1001);
        add("ovf_rne",  32'h7f00_0000, 2'd0, 32'h7f80_0000);
        add("ovf_rz",   32'h7f00_0000, 2'd3, 32'h7f7f_ffff);
        add("ovf_dn",   32'h7f00_0000, 2'd1, 32'h7f7f_ffff);
        add("ovf_up",   32'h7f00_0000, 2'd2, 32'h7f80_0000);
        add("nan",      32'h7fa0_0000, 2'd0, 32'h7fc0_0000);
        add("ninf",     32'hff80_0000, 2'd0, 32'h7f80_0000);
        add("nzero",    32'h8000_0000, 2'd0, 32'h0000_0000);
        add("minnorm",  32'h2000_0000, 2'd0, 32'h0080_0000);
        add("dnin_rne", 32'h0000_0001, 2'd0, 32'h0000_0000);
`ifdef FSQUARE_DENORM_EN
        add("uflow",    32'h1f80_0000, 2'd0, 32'h0020_0000);
        add("dnin_up",  32'h0000_0001, 2'd2, 32'h0000_0001);
`else
        add("uflow",    32'h1f80_0000, 2'd0, 32'h0000_0000);
        add("dnin_up",  32'h0000_0001, 2'd2, 32'h0000_0000);
`endif

        // Back-to-back: each request is issued on the cycle DONE returns to IDLE.
        foreach (vecs[i]) begin
            issue(vecs[i].nm, vecs[i].d, vecs[i].rm, vecs[i].s);
            wait_done(vecs[i].nm, 15, -1);
        end

        issue("ena_freeze", 32'h4040_0000, 2'd0, 32'h4110_0000);
        wait_done("ena_freeze", 20, 4);
        bus.fsq = 1'b0;
        @(posedge clk);
        #1;

        // Abort mid-multiply with reset; no result may appear for this request.
        bus.d = 32'h3fc0_0000; bus.rm = 2'b00; bus.fsq = 1'b1;
        n = 0; hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy && bus.count == 4'd5) hit = 1'b1;
        end
        chk("abort_reached_mul", 32'(hit), 32'd1);
        clrn = 1'b0;
        #1;
        chk("abort_count", 32'(bus.count), 32'd0);
        chk("abort_s", bus.s, 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_stall", 32'(bus.stall), 32'd1);
        bus.fsq = 1'b0;
        #1;
        chk("abort_stall_nofsq", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b1;

        issue("after_rst", 32'hc000_0000, 2'd3, 32'h4080_0000);
        wait_done("after_rst", 15, -1);
        bus.fsq = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
